// File: rtl/addsub_pkg.sv
// Shared definitions for the bit-serial adder/subtractor:
// controller state encoding and the default operand width.
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int WIDTH_DEFAULT = 8;

endpackage

// File: rtl/full_adder_1b.sv
// One-bit full adder. The serial datapath reuses this single cell every
// RUN cycle, feeding its carry back through a register.
module full_adder_1b (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_c
);

  assign o_s = i_a ^ i_b ^ i_c;
  assign o_c = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial unsigned adder/subtractor, LSB first, one bit per clock.
// Subtraction is A + ~B + 1: B is inverted bit by bit and the carry is
// preloaded with Sub.
// Optional feature: define SERIAL_ADDSUB_SIGNED_EN to add the signed
// overflow output Ovf (carry into MSB XOR carry out of MSB).
module serial_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             Sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             Co,
  output logic             valid
`ifdef SERIAL_ADDSUB_SIGNED_EN
  ,
  output logic             Ovf
`endif
);

  // Counter must be able to hold WIDTH itself: RUN walks cnt = 0..WIDTH,
  // with cnt = WIDTH being the wrap-up cycle that hands off to DONE.
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH);
`ifdef SERIAL_ADDSUB_SIGNED_EN
  localparam logic [CNT_W-1:0] MSB_CNT  = CNT_W'(WIDTH - 1);
`endif

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_sub;
  logic             r_carry;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_result;
  logic             r_co;
  logic             r_valid;
`ifdef SERIAL_ADDSUB_SIGNED_EN
  logic             r_cmsb;
  logic             r_ovf;
`endif

  logic w_a;
  logic w_b;
  logic w_s;
  logic w_c;

  // Current operand bits; B is conditionally inverted for subtraction.
  assign w_a = r_a[0];
  assign w_b = r_b[0] ^ r_sub;

  full_adder_1b u_fa (
    .i_a (w_a),
    .i_b (w_b),
    .i_c (r_carry),
    .o_s (w_s),
    .o_c (w_c)
  );

  // Controller, operand shifters and registered outputs in one FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_sum    <= '0;
      r_sub    <= 1'b0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
      r_co     <= 1'b0;
      r_valid  <= 1'b0;
`ifdef SERIAL_ADDSUB_SIGNED_EN
      r_cmsb   <= 1'b0;
      r_ovf    <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a     <= A;
            r_b     <= B;
            r_sub   <= Sub;
            r_carry <= Sub;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end
        end
        RUN: begin
          if (r_cnt == LAST_CNT) begin
            // All bits processed: publish result alongside the done pulse.
            r_result <= r_sum;
            r_co     <= r_carry;
            r_valid  <= ~(r_sub ^ r_carry);
`ifdef SERIAL_ADDSUB_SIGNED_EN
            r_ovf    <= r_cmsb ^ r_carry;
`endif
            r_done   <= 1'b1;
            r_state  <= DONE;
          end else begin
            r_a     <= r_a >> 1;
            r_b     <= r_b >> 1;
            r_sum   <= {w_s, r_sum[WIDTH-1:1]};
            r_carry <= w_c;
            r_cnt   <= r_cnt + 1'b1;
`ifdef SERIAL_ADDSUB_SIGNED_EN
            // Remember the carry entering the MSB for the overflow flag.
            if (r_cnt == MSB_CNT) r_cmsb <= r_carry;
`endif
          end
        end
        DONE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;
  assign Co     = r_co;
  assign valid  = r_valid;
`ifdef SERIAL_ADDSUB_SIGNED_EN
  assign Ovf    = r_ovf;
`endif

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub (WIDTH=8): directed cases,
// randomized operations against an arithmetic reference, start-ignore,
// mid-run reset and back-to-back operation.
module tb_serial_addsub;

  localparam int W = 8;
  localparam int LAT = W + 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         Sub = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         Co;
  logic         valid;
`ifdef SERIAL_ADDSUB_SIGNED_EN
  logic         Ovf;
`endif

  int total = 0;
  int bad = 0;

  serial_addsub #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .Sub    (Sub),
    .A      (A),
    .B      (B),
    .busy   (busy),
    .done   (done),
    .result (result),
    .Co     (Co),
    .valid  (valid)
`ifdef SERIAL_ADDSUB_SIGNED_EN
    ,
    .Ovf    (Ovf)
`endif
  );

  always #5 clk = ~clk;

  // Reference: plain integer arithmetic on the operands.
  function automatic void model(input int a, input int b, input bit s,
                                output int r, output bit co, output bit v,
                                output bit ov);
    int sa, sb, t;
    sa = (a >= 128) ? a - 256 : a;
    sb = (b >= 128) ? b - 256 : b;
    if (s) begin
      r  = (a - b + 256) % 256;
      co = (a >= b);
      t  = sa - sb;
    end else begin
      r  = (a + b) % 256;
      co = (a + b) > 255;
      t  = sa + sb;
    end
    v  = s ? co : !co;
    ov = (t > 127) || (t < -128);
  endfunction

  task automatic start_op(input int a, input int b, input bit s);
    @(negedge clk);
    A = a[W-1:0]; B = b[W-1:0]; Sub = s; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits for done; n counts rising edges since the accepting edge.
  task automatic wait_done(input int n0, output int n);
    n = n0;
    while (n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (done) break;
    end
  endtask

  task automatic do_op(input int a, input int b, input bit s, output int lat,
                       output int r, output bit co, output bit v,
                       output bit ov, output bit bsy);
    start_op(a, b, s);
    wait_done(0, lat);
    r = int'(result); co = Co; v = valid; bsy = busy;
`ifdef SERIAL_ADDSUB_SIGNED_EN
    ov = Ovf;
`else
    ov = 1'b0;
`endif
  endtask

  task automatic test_reset;
    #1;
    total++; if (busy !== 1'b0)  begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0)  begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    total++; if (result !== '0)  begin bad++; $display("FAIL reset_result got=%0d exp=0", result); end
    total++; if (Co !== 1'b0)    begin bad++; $display("FAIL reset_co got=%b exp=0", Co); end
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", valid); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_and_check(input string tag, input int a, input int b, input bit s);
    int lat, r, er;
    bit co, v, ov, bsy, eco, ev, eov;
    model(a, b, s, er, eco, ev, eov);
    do_op(a, b, s, lat, r, co, v, ov, bsy);
    total++; if (lat !== LAT) begin bad++; $display("FAIL %s_latency got=%0d exp=%0d", tag, lat, LAT); end
    total++; if (r !== er)    begin bad++; $display("FAIL %s_result a=%0d b=%0d sub=%0d got=%0d exp=%0d", tag, a, b, s, r, er); end
    total++; if (co !== eco)  begin bad++; $display("FAIL %s_co a=%0d b=%0d sub=%0d got=%0d exp=%0d", tag, a, b, s, co, eco); end
    total++; if (v !== ev)    begin bad++; $display("FAIL %s_valid a=%0d b=%0d sub=%0d got=%0d exp=%0d", tag, a, b, s, v, ev); end
    total++; if (bsy !== 1'b1) begin bad++; $display("FAIL %s_busy_in_done got=%0d exp=1", tag, bsy); end
`ifdef SERIAL_ADDSUB_SIGNED_EN
    total++; if (ov !== eov)  begin bad++; $display("FAIL %s_ovf a=%0d b=%0d sub=%0d got=%0d exp=%0d", tag, a, b, s, ov, eov); end
`endif
  endtask

  task automatic test_directed;
    int lat, r;
    bit co, v, ov, bsy;
    // Explicit expected values for the documented cases.
    do_op(200, 100, 1'b0, lat, r, co, v, ov, bsy);
    total++; if (lat !== 9 || r !== 44 || co !== 1'b1 || v !== 1'b0) begin
      bad++; $display("FAIL add_200_100 got lat=%0d r=%0d co=%0d v=%0d exp lat=9 r=44 co=1 v=0", lat, r, co, v);
    end
    total++; @(negedge clk); if (done !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL done_pulse_width got done=%0d busy=%0d exp 0 0", done, busy);
    end
    do_op(100, 27, 1'b0, lat, r, co, v, ov, bsy);
    total++; if (r !== 127 || co !== 1'b0 || v !== 1'b1) begin
      bad++; $display("FAIL add_100_27 got r=%0d co=%0d v=%0d exp r=127 co=0 v=1", r, co, v);
    end
`ifdef SERIAL_ADDSUB_SIGNED_EN
    total++; if (ov !== 1'b0) begin bad++; $display("FAIL ovf_100_27 got=%0d exp=0", ov); end
    do_op(100, 100, 1'b0, lat, r, co, v, ov, bsy);
    total++; if (ov !== 1'b1) begin bad++; $display("FAIL ovf_100_100 got=%0d exp=1", ov); end
`endif
    do_op(50, 20, 1'b1, lat, r, co, v, ov, bsy);
    total++; if (r !== 30 || co !== 1'b1 || v !== 1'b1) begin
      bad++; $display("FAIL sub_50_20 got r=%0d co=%0d v=%0d exp r=30 co=1 v=1", r, co, v);
    end
    do_op(20, 50, 1'b1, lat, r, co, v, ov, bsy);
    total++; if (r !== 226 || co !== 1'b0 || v !== 1'b0) begin
      bad++; $display("FAIL sub_20_50 got r=%0d co=%0d v=%0d exp r=226 co=0 v=0", r, co, v);
    end
    // Boundary operands.
    run_and_check("edge_ff_ff_add", 255, 255, 1'b0);
    run_and_check("edge_0_ff_sub", 0, 255, 1'b1);
    run_and_check("edge_0_0_sub", 0, 0, 1'b1);
    run_and_check("edge_ff_1_add", 255, 1, 1'b0);
  endtask

  task automatic test_random;
    for (int i = 0; i < 40; i++) begin
      run_and_check("rand", int'($urandom_range(255)), int'($urandom_range(255)), 1'($urandom_range(1)));
    end
  endtask

  task automatic test_start_ignored;
    int lat, er;
    bit eco, ev, eov;
    model(77, 200, 1'b1, er, eco, ev, eov);
    start_op(77, 200, 1'b1);
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    A = 8'd9; B = 8'd3; Sub = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    wait_done(3, lat);
    total++; if (lat !== LAT) begin bad++; $display("FAIL ignore_latency got=%0d exp=%0d", lat, LAT); end
    total++; if (int'(result) !== er || Co !== eco || valid !== ev) begin
      bad++; $display("FAIL ignore_result got r=%0d co=%0d v=%0d exp r=%0d co=%0d v=%0d", result, Co, valid, er, eco, ev);
    end
    // No second operation should follow from the ignored pulse.
    repeat (12) @(posedge clk);
    @(negedge clk);
    total++; if (busy !== 1'b0 || int'(result) !== er) begin
      bad++; $display("FAIL ignore_no_rerun got busy=%0d r=%0d exp busy=0 r=%0d", busy, result, er);
    end
  endtask

  task automatic test_reset_mid_run;
    bit seen;
    run_and_check("pre_reset", 200, 100, 1'b0);
    start_op(123, 45, 1'b0);
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++; if (busy !== 1'b0 || done !== 1'b0 || result !== '0 || Co !== 1'b0 || valid !== 1'b0) begin
      bad++; $display("FAIL midrun_reset got busy=%0d done=%0d r=%0d co=%0d v=%0d exp all 0", busy, done, result, Co, valid);
    end
`ifdef SERIAL_ADDSUB_SIGNED_EN
    total++; if (Ovf !== 1'b0) begin bad++; $display("FAIL midrun_reset_ovf got=%0d exp=0", Ovf); end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL midrun_no_done got activity=%0d exp=0", seen); end
    run_and_check("post_reset", 123, 45, 1'b0);
  endtask

  task automatic test_back_to_back;
    run_and_check("b2b_0", 13, 250, 1'b1);
    run_and_check("b2b_1", 128, 128, 1'b0);
    run_and_check("b2b_2", 127, 128, 1'b1);
  endtask

  initial begin
    test_reset;
    test_directed;
    test_random;
    test_start_ignored;
    test_reset_mid_run;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
